// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches to instruction memory
// and queues returned words in order for decode, discarding younger work on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  slot_pc   [DEPTH];
  logic [XLEN-1:0]  slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [DEPTH-1:0] filled_nxt;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] fill_ptr;
  logic [CNT_W-1:0] alloc_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] filled_cnt;
  logic [CNT_W-1:0] unfilled_cnt;
  logic [SUM_W-1:0] occupancy;
  logic             pop;
  logic             issue;
  logic             rsp_keep;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decisions; stale responses still occupy budget until they return.
  always_comb begin
    filled_cnt     = CNT_W'($countones(slot_filled));
    unfilled_cnt   = alloc_cnt - filled_cnt;
    occupancy      = SUM_W'(alloc_cnt) + SUM_W'(drop_cnt);
    instr_valid    = reset_n & slot_filled[head] & (alloc_cnt != '0) & ~redirect_valid;
    pop            = instr_valid & instr_ready;
    imem_req_valid = reset_n & ~redirect_valid & ((occupancy - SUM_W'(pop)) < SUM_W'(DEPTH));
    issue          = imem_req_valid & imem_req_ready;
    rsp_keep       = imem_rsp_valid & (drop_cnt == '0);
    filled_nxt     = slot_filled;
    if (pop) begin
      filled_nxt[head] = 1'b0;
    end
    if (issue) begin
      filled_nxt[tail] = 1'b0;
    end
    if (rsp_keep) begin
      filled_nxt[fill_ptr] = 1'b1;
    end
  end

  assign imem_addr      = fetch_pc;
  assign instr          = slot_data[head];
  assign op             = slot_data[head][6:0];
  assign instr_pc       = slot_pc[head];
  assign instr_pc_plus4 = slot_pc[head] + XLEN'(4);

  // Control state; redirect flushes the queue and converts outstanding fetches to drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & ~XLEN'(3);
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_cnt   <= '0;
      slot_filled <= '0;
      drop_cnt    <= CNT_W'(SUM_W'(drop_cnt) + SUM_W'(unfilled_cnt) - SUM_W'(imem_rsp_valid));
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tail     <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      if (rsp_keep) begin
        fill_ptr <= ptr_inc(fill_ptr);
      end else if (imem_rsp_valid) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      alloc_cnt   <= alloc_cnt + CNT_W'(issue) - CNT_W'(pop);
      slot_filled <= filled_nxt;
    end
  end

  // Slot payload storage needs no reset; filled bits qualify it.
  always_ff @(posedge clk) begin
    if (issue) begin
      slot_pc[tail] <= fetch_pc;
    end
    if (rsp_keep && !redirect_valid) begin
      slot_data[fill_ptr] <= imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with variable latency, scoreboard of expected
// deliveries, and a table of redirect scenarios with fixed timing expectations.
module tb_fetch_unit;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; bit filled; } exp_t;
  typedef struct { logic [31:0] pc; int unsigned due; int unsigned epoch; } mreq_t;
  typedef struct {
    logic [31:0] target;
    int unsigned lat;
    int unsigned want_unfilled;
    bit          want_head_filled;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
    logic [31:0] exp_plus4;
  } row_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] exp_fpc;
  int unsigned cyc, epoch, lat_min, lat_max, acc_cnt, delivered;
  bit          s_rst_n, s_redirect, s_ready, s_rdy_rand, s_dec_rand;
  logic [31:0] s_redirect_pc;
  bit          smp_req_valid, smp_ivalid;
  logic [31:0] smp_addr, smp_ipc, smp_plus4;
  int          checks, errors;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs at negedge, compare against the model, advance the model.
  task automatic cycle();
    bit rsp_now, rsp_stale, pop, acc, exp_req, exp_iv;
    int stale_n, occ;
    exp_t e;
    @(negedge clk);
    reset_n        = s_rst_n;
    redirect_valid = s_redirect;
    redirect_pc    = s_redirect_pc;
    instr_ready    = s_dec_rand ? 1'($urandom_range(0, 1)) : s_ready;
    imem_req_ready = s_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    rsp_now = 0; rsp_stale = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (s_rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_now        = 1;
      rsp_stale      = (mem_q[0].epoch != epoch);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].pc);
      void'(mem_q.pop_front());
    end
    stale_n = int'(rsp_stale);
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale_n++;
    exp_iv  = s_rst_n && !s_redirect && exp_q.size() > 0 && exp_q[0].filled;
    pop     = exp_iv && instr_ready;
    occ     = exp_q.size() + stale_n - int'(pop);
    exp_req = s_rst_n && !s_redirect && (occ < int'(DEPTH));
    #1;
    smp_req_valid = imem_req_valid;
    smp_addr      = imem_addr;
    smp_ivalid    = instr_valid;
    smp_ipc       = instr_pc;
    smp_plus4     = instr_pc_plus4;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_addr, exp_fpc);
    chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("instr", instr, exp_q[0].data);
      chk("op", 32'(op), 32'(exp_q[0].data[6:0]));
      chk("instr_pc", instr_pc, exp_q[0].pc);
      chk("instr_pc_plus4", instr_pc_plus4, exp_q[0].pc + 32'd4);
    end
    acc = exp_req && imem_req_ready;
    if (!s_rst_n) begin
      exp_q.delete();
      mem_q.delete();
      exp_fpc = RESET_PC;
    end else if (s_redirect) begin
      exp_q.delete();
      exp_fpc = s_redirect_pc & ~32'h3;
      epoch++;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (rsp_now && !rsp_stale) begin
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!exp_q[i].filled) begin
            e = exp_q[i];
            e.filled = 1'b1;
            exp_q[i] = e;
            break;
          end
        end
      end
      if (acc) begin
        mem_q.push_back('{pc: exp_fpc, due: cyc + $urandom_range(lat_min, lat_max), epoch: epoch});
        exp_q.push_back('{pc: exp_fpc, data: mem_word(exp_fpc), filled: 1'b0});
        exp_fpc = exp_fpc + 32'd4;
        acc_cnt++;
      end
    end
    cyc++;
  endtask

  function automatic bit row_ready(input row_t r);
    int unsigned unf = 0;
    foreach (exp_q[i]) if (!exp_q[i].filled) unf++;
    if (unf != r.want_unfilled) return 0;
    if (mem_q.size() == 0 || mem_q[0].due > cyc || mem_q[0].epoch != epoch) return 0;
    if (r.want_head_filled && !(exp_q.size() > 0 && exp_q[0].filled)) return 0;
    return 1;
  endfunction

  initial begin
    row_t rows[4];
    int unsigned n0, d0;
    logic [31:0] stall_pc;
    bit found;

    rows[0] = '{32'h0000_0203, 2, 2, 1'b0, 32'h0000_0200, 32'h0000_0204, 32'h0000_0204};
    rows[1] = '{32'h0000_1001, 1, 1, 1'b1, 32'h0000_1000, 32'h0000_1004, 32'h0000_1004};
    rows[2] = '{32'hFFFF_FFFE, 1, 1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    rows[3] = '{32'h7FFF_FFF8, 3, 2, 1'b0, 32'h7FFF_FFF8, 32'h7FFF_FFFC, 32'h7FFF_FFFC};

    checks = 0; errors = 0; cyc = 0; epoch = 0; acc_cnt = 0; delivered = 0;
    lat_min = 1; lat_max = 1; exp_fpc = RESET_PC;
    s_rst_n = 0; s_redirect = 0; s_redirect_pc = '0; s_ready = 1; s_rdy_rand = 0; s_dec_rand = 0;
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Reset release and first-fetch timing
    repeat (3) cycle();
    s_rst_n = 1;
    cycle();
    chk("first_req_valid", 32'(smp_req_valid), 32'd1);
    chk("first_req_addr", smp_addr, 32'h0000_0100);
    cycle();
    chk("first_n1_ivalid", 32'(smp_ivalid), 32'd0);
    cycle();
    chk("first_ivalid", 32'(smp_ivalid), 32'd1);
    chk("first_pc", smp_ipc, 32'h0000_0100);
    chk("first_plus4", smp_plus4, 32'h0000_0104);
    cycle();
    chk("second_pc", smp_ipc, 32'h0000_0104);
    cycle();
    chk("third_pc", smp_ipc, 32'h0000_0108);
    repeat (3) cycle();

    // Decode stall: bounded issue and frozen head
    s_ready = 0;
    stall_pc = exp_q[0].pc;
    n0 = acc_cnt;
    repeat (5) cycle();
    chk("stall_req_bound", 32'(acc_cnt - n0 <= DEPTH), 32'd1);
    chk("stall_head_pc", smp_ipc, stall_pc);
    chk("stall_ivalid", 32'(smp_ivalid), 32'd1);
    s_ready = 1;
    repeat (8) cycle();

    // Redirect table
    for (int r = 0; r < 4; r++) begin
      lat_min = rows[r].lat;
      lat_max = rows[r].lat;
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
        if (row_ready(rows[r])) found = 1;
        else cycle();
      end
      chk($sformatf("row%0d_setup", r), 32'(found), 32'd1);
      if (found) begin
        lat_min = 1; lat_max = 1;
        s_redirect = 1; s_redirect_pc = rows[r].target;
        cycle();
        s_redirect = 0;
        chk($sformatf("row%0d_r_ivalid", r), 32'(smp_ivalid), 32'd0);
        chk($sformatf("row%0d_r_req", r), 32'(smp_req_valid), 32'd0);
        cycle();
        chk($sformatf("row%0d_r1_req", r), 32'(smp_req_valid), 32'd1);
        chk($sformatf("row%0d_r1_addr", r), smp_addr, rows[r].exp_addr);
        cycle();
        chk($sformatf("row%0d_r2_ivalid", r), 32'(smp_ivalid), 32'd0);
        chk($sformatf("row%0d_r2_addr", r), smp_addr, rows[r].exp_next);
        cycle();
        chk($sformatf("row%0d_r3_ivalid", r), 32'(smp_ivalid), 32'd1);
        chk($sformatf("row%0d_r3_pc", r), smp_ipc, rows[r].exp_addr);
        chk($sformatf("row%0d_r3_plus4", r), smp_plus4, rows[r].exp_plus4);
        repeat (4) cycle();
      end
    end

    // Random memory backpressure, latency, decode readiness and occasional redirects
    s_rdy_rand = 1; s_dec_rand = 1; lat_min = 1; lat_max = 4;
    d0 = delivered;
    for (int i = 0; i < 500; i++) begin
      s_redirect = ($urandom_range(0, 39) == 0);
      s_redirect_pc = $urandom();
      cycle();
    end
    s_redirect = 0;
    chk("random_progress", 32'(delivered - d0 > 30), 32'd1);

    // Reset mid-operation
    repeat (3) cycle();
    s_rdy_rand = 0; s_dec_rand = 0; s_ready = 1; lat_min = 1; lat_max = 1;
    s_rst_n = 0;
    repeat (2) cycle();
    chk("midrst_ivalid", 32'(smp_ivalid), 32'd0);
    s_rst_n = 1;
    cycle();
    chk("midrst_req_addr", smp_addr, RESET_PC);
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
